// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared constants, entry layout and helpers for the
// writeback arbiter.
//   WB_DATA_W / WB_ADDR_W : default value / register address widths
//   NUM_REQ               : number of producers (execA, execB, load/store)
//   REQ_*                 : producer indices within the packed request buses
//   wb_entry_t            : one queued writeback {addr, val, status}
//   rr_wrap()             : reduce a 0..5 sum back into the 0..2 producer range
package wb_arbiter_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 5;
    localparam int NUM_REQ   = 3;

    localparam int REQ_EXECA = 0;
    localparam int REQ_EXECB = 1;
    localparam int REQ_LS    = 2;

    // Field order matches the flat FIFO word: {addr, val, status}.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] val;
        logic [1:0]           status;
    } wb_entry_t;

    function automatic logic [1:0] rr_wrap(input logic [2:0] v);
        logic [2:0] r;
        r = (v >= 3'd3) ? (v - 3'd3) : v;
        return r[1:0];
    endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// wb_arb_fifo: single-producer FIFO feeding one arbiter input.
//   clock_i, reset_i : clock, synchronous active-high reset
//   flush_i          : empties the FIFO; a push in the same cycle is dropped
//   push_i / pop_i   : enqueue din_i / dequeue the head (ignored when full/empty)
//   full_o, empty_o  : occupancy flags, from the count register only
//   head_o           : current head entry (valid when !empty_o)
module wb_arb_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];

    // A full FIFO refuses a push even while popping.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop_ok)
            cnt_d = cnt_q + (PW+1)'(1);
        else if (!push_ok && pop_ok)
            cnt_d = cnt_q - (PW+1)'(1);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + PW'(1);
            if (pop_ok)  rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; the count alone defines which slots are live.
    always_ff @(posedge clock_i) begin
        if (!reset_i && !flush_i && push_ok)
            mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges writebacks from execA, execB and load/store onto the
// register unit's two writeback ports, round-robin, never writing the same
// register twice in one cycle.
//   clock_i, reset_i        : clock, synchronous active-high reset
//   flushBack_i             : discard every queued writeback
//   reqValid_i/reqAddr_i/reqVal_i/reqStatus_i : per-producer request, packed by index
//   reqReady_o              : per-producer FIFO not full (0 while in reset)
//   wbA_o/wbB_o             : registered write strobes for port A / B
//   wbAddr*_o/wbVal*_o/operationStatus*_o : registered write payload (holds when idle)
// Optional (WB_ARBITER_PERF_EN): conflictCnt_o, fullCnt_o saturating 16-bit
// event counters.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    flushBack_i,
    input  logic [NUM_REQ-1:0]      reqValid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] reqAddr_i,
    input  logic [NUM_REQ*DATA_W-1:0] reqVal_i,
    input  logic [NUM_REQ*2-1:0]    reqStatus_i,
    output logic [NUM_REQ-1:0]      reqReady_o,
    output logic                    wbA_o,
    output logic                    wbB_o,
    output logic [ADDR_W-1:0]       wbAddrA_o,
    output logic [ADDR_W-1:0]       wbAddrB_o,
    output logic [DATA_W-1:0]       wbValA_o,
    output logic [DATA_W-1:0]       wbValB_o,
    output logic [1:0]              operationStatusA_o,
    output logic [1:0]              operationStatusB_o
`ifdef WB_ARBITER_PERF_EN
    ,
    output logic [15:0]             conflictCnt_o,
    output logic [15:0]             fullCnt_o
`endif
);

    localparam int ENTRY_W = ADDR_W + DATA_W + 2;

    logic [NUM_REQ-1:0] full, empty, push, pop, cand;
    logic [ENTRY_W-1:0] head      [NUM_REQ];
    logic [ADDR_W-1:0]  head_addr [NUM_REQ];
    logic [DATA_W-1:0]  head_val  [NUM_REQ];
    logic [1:0]         head_st   [NUM_REQ];

    logic [1:0] rr_q, rr_d;
    logic       gnt_a, gnt_b;
    logic [1:0] idx_a, idx_b;
    logic [1:0] ord [NUM_REQ];

    logic              wbA_q, wbB_q;
    logic [ADDR_W-1:0] addrA_q, addrB_q;
    logic [DATA_W-1:0] valA_q, valB_q;
    logic [1:0]        stA_q, stB_q;

    // Ready is gated by reset so producers see "not ready" during the reset
    // cycle regardless of what the FIFOs held.
    assign reqReady_o = ~full & {NUM_REQ{~reset_i}};

    // Nothing is a candidate during a flush: grants would pop entries that
    // the flush is about to discard anyway.
    assign cand = ~empty & {NUM_REQ{~flushBack_i}};

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign push[g] = reqValid_i[g] & reqReady_o[g];

        wb_arb_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock_i (clock_i),
            .reset_i (reset_i),
            .flush_i (flushBack_i),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .din_i   ({reqAddr_i[g*ADDR_W +: ADDR_W],
                       reqVal_i[g*DATA_W +: DATA_W],
                       reqStatus_i[g*2 +: 2]}),
            .full_o  (full[g]),
            .empty_o (empty[g]),
            .head_o  (head[g])
        );

        assign head_addr[g] = head[g][ENTRY_W-1 -: ADDR_W];
        assign head_val[g]  = head[g][DATA_W+1:2];
        assign head_st[g]   = head[g][1:0];
        assign ord[g]       = rr_wrap({1'b0, rr_q} + 3'(g));
    end

`ifdef WB_ARBITER_PERF_EN
    logic conflict;
`endif

    // Scan rr, rr+1, rr+2: first candidate takes A, the next candidate with a
    // different address takes B; same-address heads are skipped and stay queued.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        idx_a = '0;
        idx_b = '0;
`ifdef WB_ARBITER_PERF_EN
        conflict = 1'b0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            if (cand[ord[k]]) begin
                if (!gnt_a) begin
                    gnt_a = 1'b1;
                    idx_a = ord[k];
                end else if (!gnt_b) begin
                    if (head_addr[ord[k]] != head_addr[idx_a]) begin
                        gnt_b = 1'b1;
                        idx_b = ord[k];
                    end
`ifdef WB_ARBITER_PERF_EN
                    else begin
                        conflict = 1'b1;
                    end
`endif
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        if (gnt_a) pop[idx_a] = 1'b1;
        if (gnt_b) pop[idx_b] = 1'b1;
    end

    // B is always later in the scan than A, so it is the last grant when present.
    always_comb begin
        rr_d = rr_q;
        if (gnt_b)
            rr_d = rr_wrap({1'b0, idx_b} + 3'd1);
        else if (gnt_a)
            rr_d = rr_wrap({1'b0, idx_a} + 3'd1);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rr_q    <= '0;
            wbA_q   <= 1'b0;
            wbB_q   <= 1'b0;
            addrA_q <= '0;
            addrB_q <= '0;
            valA_q  <= '0;
            valB_q  <= '0;
            stA_q   <= '0;
            stB_q   <= '0;
        end else begin
            rr_q  <= rr_d;
            wbA_q <= gnt_a;
            wbB_q <= gnt_b;
            if (gnt_a) begin
                addrA_q <= head_addr[idx_a];
                valA_q  <= head_val[idx_a];
                stA_q   <= head_st[idx_a];
            end
            if (gnt_b) begin
                addrB_q <= head_addr[idx_b];
                valB_q  <= head_val[idx_b];
                stB_q   <= head_st[idx_b];
            end
        end
    end

    assign wbA_o              = wbA_q;
    assign wbB_o              = wbB_q;
    assign wbAddrA_o          = addrA_q;
    assign wbAddrB_o          = addrB_q;
    assign wbValA_o           = valA_q;
    assign wbValB_o           = valB_q;
    assign operationStatusA_o = stA_q;
    assign operationStatusB_o = stB_q;

`ifdef WB_ARBITER_PERF_EN
    logic [15:0] conflict_cnt_q, full_cnt_q;
    logic        full_evt;

    assign full_evt = |(reqValid_i & ~reqReady_o);

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            conflict_cnt_q <= '0;
            full_cnt_q     <= '0;
        end else begin
            if (conflict && conflict_cnt_q != 16'hFFFF)
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            if (full_evt && full_cnt_q != 16'hFFFF)
                full_cnt_q <= full_cnt_q + 16'd1;
        end
    end

    assign conflictCnt_o = conflict_cnt_q;
    assign fullCnt_o     = full_cnt_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] val;
        logic [1:0]  st;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [2:0]  vld;
    logic [4:0]  a [3];
    logic [15:0] v [3];
    logic [1:0]  s [3];
    logic [14:0] addr_bus;
    logic [47:0] val_bus;
    logic [5:0]  st_bus;
    logic [2:0]  rdy;
    logic        wbA, wbB;
    logic [4:0]  addrA, addrB;
    logic [15:0] valA, valB;
    logic [1:0]  stA, stB;
`ifdef WB_ARBITER_PERF_EN
    logic [15:0] conflictCnt, fullCnt;
`endif

    assign addr_bus = {a[2], a[1], a[0]};
    assign val_bus  = {v[2], v[1], v[0]};
    assign st_bus   = {s[2], s[1], s[0]};

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clock_i            (clk),
        .reset_i            (rst),
        .flushBack_i        (flush),
        .reqValid_i         (vld),
        .reqAddr_i          (addr_bus),
        .reqVal_i           (val_bus),
        .reqStatus_i        (st_bus),
        .reqReady_o         (rdy),
        .wbA_o              (wbA),
        .wbB_o              (wbB),
        .wbAddrA_o          (addrA),
        .wbAddrB_o          (addrB),
        .wbValA_o           (valA),
        .wbValB_o           (valB),
        .operationStatusA_o (stA),
        .operationStatusB_o (stB)
`ifdef WB_ARBITER_PERF_EN
        ,
        .conflictCnt_o      (conflictCnt),
        .fullCnt_o          (fullCnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one queue per producer plus expected output registers.
    ent_t        mq [3][$];
    int          mrr = 0;
    bit          macc [3];
    logic        e_wbA, e_wbB;
    logic [4:0]  e_addrA, e_addrB;
    logic [15:0] e_valA, e_valB;
    logic [1:0]  e_stA, e_stB;
    logic [15:0] e_conf, e_full;

    function automatic logic [2:0] exp_ready();
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = !rst && (mq[i].size() < 4);
        return r;
    endfunction

    // One clock edge: DUT and model advance on the inputs currently driven.
    task automatic tick();
        logic [2:0] r;
        bit fullev;
        int ga, gb;
        bit cf;
        r = exp_ready();
        fullev = 0;
        for (int i = 0; i < 3; i++) begin
            macc[i] = vld[i] && r[i];
            if (vld[i] && !r[i]) fullev = 1;
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            mrr = 0;
            e_wbA = 0; e_wbB = 0; e_addrA = 0; e_addrB = 0;
            e_valA = 0; e_valB = 0; e_stA = 0; e_stB = 0;
            e_conf = 0; e_full = 0;
        end else begin
            if (fullev && e_full != 16'hFFFF) e_full++;
            if (flush) begin
                for (int i = 0; i < 3; i++) mq[i].delete();
                e_wbA = 0; e_wbB = 0;
            end else begin
                ga = -1; gb = -1; cf = 0;
                for (int k = 0; k < 3; k++) begin
                    int p;
                    p = (mrr + k) % 3;
                    if (mq[p].size() > 0) begin
                        if (ga < 0) ga = p;
                        else if (gb < 0) begin
                            if (mq[p][0].addr != mq[ga][0].addr) gb = p;
                            else cf = 1;
                        end
                    end
                end
                if (cf && e_conf != 16'hFFFF) e_conf++;
                e_wbA = (ga >= 0);
                e_wbB = (gb >= 0);
                if (ga >= 0) begin
                    e_addrA = mq[ga][0].addr; e_valA = mq[ga][0].val; e_stA = mq[ga][0].st;
                end
                if (gb >= 0) begin
                    e_addrB = mq[gb][0].addr; e_valB = mq[gb][0].val; e_stB = mq[gb][0].st;
                end
                if (ga >= 0) void'(mq[ga].pop_front());
                if (gb >= 0) void'(mq[gb].pop_front());
                if (gb >= 0) mrr = (gb + 1) % 3;
                else if (ga >= 0) mrr = (ga + 1) % 3;
                for (int i = 0; i < 3; i++)
                    if (macc[i]) mq[i].push_back('{addr: a[i], val: v[i], st: s[i]});
            end
        end
        #1;
    endtask

    task automatic idle();
        flush = 0;
        vld   = 3'b000;
        for (int i = 0; i < 3; i++) begin a[i] = 0; v[i] = 0; s[i] = 0; end
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        #1;
        total++;
        if (rdy !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", rdy); end
        tick();
        tick();
        total++;
        if ({wbA, wbB, addrA, addrB, valA, valB, stA, stB} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%b%b %h %h %h %h exp=all zero", wbA, wbB, addrA, addrB, valA, valB);
        end
        rst = 0;
        #1;
        total++;
        if (rdy !== 3'b111) begin bad++; $display("FAIL ready_after_reset got=%b exp=111", rdy); end
    endtask

    task automatic test_single();
        do_reset();
        vld[0] = 1; a[0] = 5'd3; v[0] = 16'h00AA; s[0] = 2'b00;
        tick();
        idle();
        total++;
        if (wbA !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", wbA); end
        tick();
        total++;
        if ({wbA, addrA, valA, stA, wbB} !== {1'b1, 5'd3, 16'h00AA, 2'b00, 1'b0}) begin
            bad++; $display("FAIL single_issue got=%b/%0d/%h/%b/%b exp=1/3/00aa/00/0", wbA, addrA, valA, stA, wbB);
        end
        tick();
        total++;
        if ({wbA, addrA, valA} !== {1'b0, 5'd3, 16'h00AA}) begin
            bad++; $display("FAIL single_hold got=%b/%0d/%h exp=0/3/00aa", wbA, addrA, valA);
        end
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 3; i++) begin vld[i] = 1; a[i] = 5'(i + 1); v[i] = 16'h1000 + 16'(i); s[i] = 2'(i); end
        tick();
        idle();
        tick();
        total++;
        if ({wbA, addrA, valA, wbB, addrB, valB} !== {1'b1, 5'd1, 16'h1000, 1'b1, 5'd2, 16'h1001}) begin
            bad++; $display("FAIL contend_c1 got=%b/%0d/%h %b/%0d/%h exp=1/1/1000 1/2/1001", wbA, addrA, valA, wbB, addrB, valB);
        end
        tick();
        total++;
        if ({wbA, addrA, valA, stA, wbB} !== {1'b1, 5'd3, 16'h1002, 2'd2, 1'b0}) begin
            bad++; $display("FAIL contend_c2 got=%b/%0d/%h/%b %b exp=1/3/1002/10 0", wbA, addrA, valA, stA, wbB);
        end
        total++;
        if (dut.rr_q !== 2'd0) begin bad++; $display("FAIL contend_rr got=%0d exp=0", dut.rr_q); end
    endtask

    task automatic test_conflict();
        do_reset();
        vld[0] = 1; a[0] = 5'd7; v[0] = 16'd1;
        vld[1] = 1; a[1] = 5'd7; v[1] = 16'd2;
        tick();
        idle();
        tick();
        total++;
        if ({wbA, addrA, valA, wbB} !== {1'b1, 5'd7, 16'd1, 1'b0}) begin
            bad++; $display("FAIL conflict_c1 got=%b/%0d/%h %b exp=1/7/0001 0", wbA, addrA, valA, wbB);
        end
`ifdef WB_ARBITER_PERF_EN
        total++;
        if (conflictCnt !== 16'd1) begin bad++; $display("FAIL conflict_cnt got=%0d exp=1", conflictCnt); end
`endif
        tick();
        total++;
        if ({wbA, addrA, valA, wbB} !== {1'b1, 5'd7, 16'd2, 1'b0}) begin
            bad++; $display("FAIL conflict_c2 got=%b/%0d/%h %b exp=1/7/0002 0", wbA, addrA, valA, wbB);
        end
    endtask

    // Same-address competitors limit LS to one grant in three, so its FIFO fills.
    task automatic test_full();
        int ls_sent;
        bit saw_block, saw_retry;
        logic [15:0] lsq [$];
        do_reset();
        ls_sent = 0; saw_block = 0; saw_retry = 0;
        for (int c = 0; c < 100; c++) begin
            for (int r = 0; r < 2; r++)
                if (!(vld[r] && !macc[r])) begin
                    vld[r] = (c < 20); a[r] = 5'd9; v[r] = 16'(16'h0200 * (r + 1) + c); s[r] = 0;
                end
            vld[2] = (ls_sent < 8); a[2] = 5'd9; v[2] = 16'h0100 + 16'(ls_sent); s[2] = 2'b01;
            #1;
            if (vld[2] && !rdy[2]) saw_block = 1;
            total++;
            if (rdy !== exp_ready()) begin bad++; $display("FAIL full_ready c=%0d got=%b exp=%b", c, rdy, exp_ready()); end
            tick();
            if (macc[2]) begin
                ls_sent++;
                if (saw_block) saw_retry = 1;
            end
            if (wbA && valA[15:8] == 8'h01) lsq.push_back(valA);
            if (wbB && valB[15:8] == 8'h01) lsq.push_back(valB);
            total++;
            if ({wbA, addrA, valA, stA, wbB, addrB, valB, stB} !== {e_wbA, e_addrA, e_valA, e_stA, e_wbB, e_addrB, e_valB, e_stB}) begin
                bad++; $display("FAIL full_out c=%0d got=%b/%h %b/%h exp=%b/%h %b/%h", c, wbA, valA, wbB, valB, e_wbA, e_valA, e_wbB, e_valB);
            end
        end
        idle();
        total++;
        if (!(saw_block && saw_retry)) begin bad++; $display("FAIL full_block got=%0d%0d exp=11", saw_block, saw_retry); end
        total++;
        if (lsq.size() != 8) begin bad++; $display("FAIL full_count got=%0d exp=8", lsq.size()); end
        else for (int i = 0; i < 8; i++) begin
            total++;
            if (lsq[i] !== 16'h0100 + 16'(i)) begin bad++; $display("FAIL full_order i=%0d got=%h exp=%h", i, lsq[i], 16'h0100 + 16'(i)); end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 3; i++) begin vld[i] = 1; a[i] = 5'd4; v[i] = 16'hF000 + 16'(i * 2 + c); end
            tick();
        end
        flush = 1;
        for (int i = 0; i < 3; i++) v[i] = 16'hE000 + 16'(i);
        #1;
        total++;
        if (wbA !== 1'b1) begin bad++; $display("FAIL flush_inflight got=%b exp=1", wbA); end
        tick();
        idle();
        total++;
        if ({wbA, wbB} !== 2'b00) begin bad++; $display("FAIL flush_strobe got=%b%b exp=00", wbA, wbB); end
        #1;
        total++;
        if (rdy !== 3'b111) begin bad++; $display("FAIL flush_ready got=%b exp=111", rdy); end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if ({wbA, wbB} !== 2'b00) begin bad++; $display("FAIL flush_leak c=%0d got=%b%b exp=00", c, wbA, wbB); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 3; i++) begin vld[i] = 1; a[i] = 5'd12; v[i] = 16'hC000 + 16'(c * 3 + i); end
            tick();
        end
        rst = 1;
        #1;
        total++;
        if (rdy !== 3'b000) begin bad++; $display("FAIL midrst_ready got=%b exp=000", rdy); end
        tick();
        rst = 0;
        idle();
        total++;
        if ({wbA, wbB, addrA, addrB, valA, valB, stA, stB, dut.rr_q} !== '0) begin
            bad++; $display("FAIL midrst_outputs got=%b%b %h %h rr=%0d exp=all zero", wbA, wbB, valA, valB, dut.rr_q);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if ({wbA, wbB} !== 2'b00) begin bad++; $display("FAIL midrst_leak c=%0d got=%b%b exp=00", c, wbA, wbB); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 3; r++)
                if (!(vld[r] && !macc[r])) begin
                    vld[r] = ($urandom_range(0, 99) < 65);
                    a[r]   = 5'($urandom_range(0, 3));
                    v[r]   = 16'($urandom);
                    s[r]   = 2'($urandom_range(0, 3));
                end
            flush = ($urandom_range(0, 99) < 3);
            #1;
            total++;
            if (rdy !== exp_ready()) begin bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, rdy, exp_ready()); end
            tick();
            total++;
            if ({wbA, addrA, valA, stA, wbB, addrB, valB, stB} !== {e_wbA, e_addrA, e_valA, e_stA, e_wbB, e_addrB, e_valB, e_stB}) begin
                bad++; $display("FAIL rand_out c=%0d got=%b/%0d/%h/%b %b/%0d/%h/%b exp=%b/%0d/%h/%b %b/%0d/%h/%b", c,
                    wbA, addrA, valA, stA, wbB, addrB, valB, stB, e_wbA, e_addrA, e_valA, e_stA, e_wbB, e_addrB, e_valB, e_stB);
            end
`ifdef WB_ARBITER_PERF_EN
            total++;
            if ({conflictCnt, fullCnt} !== {e_conf, e_full}) begin
                bad++; $display("FAIL rand_perf c=%0d got=%0d/%0d exp=%0d/%0d", c, conflictCnt, fullCnt, e_conf, e_full);
            end
`endif
        end
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        for (int i = 0; i < 3; i++) macc[i] = 1;
        test_reset();
        test_single();
        test_contention();
        test_conflict();
        test_full();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
